// File: rtl/mult_share_arbiter.sv
// Round-robin front end sharing one 4x4 array multiplier among NREQ requesters.
// Optional operand register stage before the multiplier: MULT_ARB_PIPE_EN.
module mult_share_arbiter #(
    parameter int NREQ = 2,
    parameter int W    = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*W-1:0]    rsp_o,
    output logic [IDW-1:0]    rsp_id
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_t;

    ostate_t        state;
    ostate_t        state_nxt;
    logic [IDW-1:0] rr;
    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    logic           in_free;
    logic           req_fire;
    logic           p_free;
    logic           p_load;
    logic [W-1:0]   p_x;
    logic [W-1:0]   p_y;
    logic [IDW-1:0] p_id;
    logic [W-1:0]   sel_x;
    logic [W-1:0]   sel_y;
    int             sel_base;
    int             srch;

    // Shift-and-add array of partial products; W-bit operands, 2W-bit result.
    function automatic logic [2*W-1:0] array_mul(
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [2*W-1:0] acc;
        acc = '0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) acc = acc + ({{W{1'b0}}, a} << i);
        end
        return acc;
    endfunction

    // Round-robin search starting at rr, wrapping modulo NREQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        srch    = 0;
        for (int k = 0; k < NREQ; k++) begin
            srch = int'(rr) + k;
            if (srch >= NREQ) srch = srch - NREQ;
            if (!gnt_any && req_valid[srch]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(srch);
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_base = int'(gnt_idx) * W;
        sel_x    = req_x[sel_base +: W];
        sel_y    = req_y[sel_base +: W];
    end

    assign p_free   = (state == EMPTY) || rsp_ready;
    assign req_fire = !rst && gnt_any && in_free;

    // One-hot grant, only when the entry stage has room; forced low in reset.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = req_fire && (gnt_idx == IDW'(i));
        end
    end

    // Pointer moves past the winner on each request transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr <= '0;
        else if (req_fire) rr <= IDW'((int'(gnt_idx) + 1) % NREQ);
    end

`ifdef MULT_ARB_PIPE_EN
    logic           op_v;
    logic [W-1:0]   op_x;
    logic [W-1:0]   op_y;
    logic [IDW-1:0] op_id;

    assign in_free = !op_v || p_free;
    assign p_load  = op_v && p_free;
    assign p_x     = op_x;
    assign p_y     = op_y;
    assign p_id    = op_id;

    // Operand stage: capture on grant, drain into the product stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_v  <= 1'b0;
            op_x  <= '0;
            op_y  <= '0;
            op_id <= '0;
        end else if (req_fire) begin
            op_v  <= 1'b1;
            op_x  <= sel_x;
            op_y  <= sel_y;
            op_id <= gnt_idx;
        end else if (p_load) begin
            op_v <= 1'b0;
        end
    end
`else
    assign in_free = p_free;
    assign p_load  = req_fire;
    assign p_x     = sel_x;
    assign p_y     = sel_y;
    assign p_id    = gnt_idx;
`endif

    // Output stage state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else state <= state_nxt;
    end

    // Output stage next state: load wins, else drain on consumer accept.
    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (p_load) state_nxt = FULL;
            FULL: begin
                if (p_load) state_nxt = FULL;
                else if (rsp_ready) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    assign rsp_valid = (state == FULL);

    // Product register; holds while stalled, overwritten on each load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_o  <= '0;
            rsp_id <= '0;
        end else if (p_load) begin
            rsp_o  <= array_mul(p_x, p_y);
            rsp_id <= p_id;
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed cases plus random
// traffic checked every cycle against a stage-occupancy reference model.
module tb_mult_share_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 4;
    localparam int IDW  = 2;
`ifdef MULT_ARB_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x = '0;
    logic [NREQ*W-1:0] req_y = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [2*W-1:0]    rsp_o;
    logic [IDW-1:0]    rsp_id;

    mult_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_o     (rsp_o),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    int m_rr;
    bit m_v[LAT];
    int m_p[LAT];
    int m_id[LAT];

    logic [NREQ-1:0] last_gnt = '0;
    logic [NREQ-1:0] o_rdy;
    logic            o_v;
    logic [2*W-1:0]  o_p;
    logic [IDW-1:0]  o_id;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_rr = 0;
        for (int k = 0; k < LAT; k++) begin
            m_v[k]  = 1'b0;
            m_p[k]  = 0;
            m_id[k] = 0;
        end
    endtask

    // One clock cycle: drive, check at negedge, advance model. Starts and
    // ends 1 time unit after a rising edge.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] x,
                        input logic [NREQ*W-1:0] y, input logic rdy);
        bit              free[LAT];
        int              g;
        int              j;
        logic [NREQ-1:0] er;
        req_valid = v;
        req_x     = x;
        req_y     = y;
        rsp_ready = rdy;
        @(negedge clk);
        free[LAT-1] = !m_v[LAT-1] || rdy;
        for (int k = LAT - 2; k >= 0; k--) free[k] = !m_v[k] || free[k+1];
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            j = (m_rr + k) % NREQ;
            if (g < 0 && v[j]) g = j;
        end
        if (!free[0]) g = -1;
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        o_rdy = req_ready;
        o_v   = rsp_valid;
        o_p   = rsp_o;
        o_id  = rsp_id;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_v[LAT-1]));
        if (m_v[LAT-1]) begin
            chk("rsp_o", 32'(rsp_o), 32'(m_p[LAT-1]));
            chk("rsp_id", 32'(rsp_id), 32'(m_id[LAT-1]));
        end
        for (int k = LAT - 1; k >= 1; k--) begin
            if (free[k]) begin
                m_v[k]  = m_v[k-1];
                m_p[k]  = m_p[k-1];
                m_id[k] = m_id[k-1];
            end
        end
        if (free[0]) begin
            m_v[0] = (g >= 0);
            if (g >= 0) begin
                m_p[0]  = int'(x[g*W +: W]) * int'(y[g*W +: W]);
                m_id[0] = g;
            end
        end
        if (g >= 0) m_rr = (g + 1) % NREQ;
        last_gnt = er;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step('0, '0, '0, rdy);
    endtask

    // Asynchronous reset between edges, checked before any clock edge.
    task automatic do_reset();
        req_valid = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_o", 32'(rsp_o), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        model_clear();
        last_gnt = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [NREQ-1:0]   rv;
    logic [NREQ*W-1:0] rx;
    logic [NREQ*W-1:0] ry;

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Basic product 15*15 on requester 0.
        step(2'b01, 8'h0F, 8'h0F, 1'b1);
        chk("basic_ready", 32'(o_rdy), 32'h1);
        idle(LAT, 1'b1);
        chk("basic_valid", 32'(o_v), 32'h1);
        chk("basic_o", 32'(o_p), 32'hE1);
        chk("basic_id", 32'(o_id), 32'h0);

        // Round-robin alternation: req0 3*5, req1 7*9.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(2'b11, 8'h73, 8'h95, 1'b1);
            chk("rr_grant", 32'(o_rdy), (k % 2 == 0) ? 32'h1 : 32'h2);
        end
        chk("rr_o", 32'(o_p), (LAT == 1) ? 32'h0F : 32'h3F);
        idle(LAT + 1, 1'b1);

        // Backpressure on a 6*6 product.
        step(2'b01, 8'h06, 8'h06, 1'b1);
        idle(LAT - 1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(2'b01, 8'h02, 8'h03, 1'b0);
            chk("bp_valid", 32'(o_v), 32'h1);
            chk("bp_o", 32'(o_p), 32'h24);
            chk("bp_ready", 32'(o_rdy), (LAT == 2 && k == 0) ? 32'h1 : 32'h0);
        end
        step(2'b01, 8'h02, 8'h03, 1'b1);
        chk("bp_release_ready", 32'(o_rdy), 32'h1);
        chk("bp_release_o", 32'(o_p), 32'h24);
        idle(LAT + 1, 1'b1);

        // Reset while holding 0x24, pointer left at requester 1.
        step(2'b01, 8'h06, 8'h06, 1'b1);
        idle(LAT, 1'b0);
        chk("pre_rst_o", 32'(o_p), 32'h24);
        do_reset();
        step(2'b11, 8'h11, 8'h11, 1'b1);
        chk("post_rst_grant", 32'(o_rdy), 32'h1);
        idle(LAT + 1, 1'b1);

        // Idle keeps pointer at 1; then 0*15 on requester 1.
        idle(3, 1'b1);
        chk("idle_valid", 32'(o_v), 32'h0);
        step(2'b11, 8'h05, 8'hF5, 1'b1);
        chk("idle_grant", 32'(o_rdy), 32'h2);
        idle(LAT, 1'b1);
        chk("zero_o", 32'(o_p), 32'h00);
        chk("zero_id", 32'(o_id), 32'h1);
        idle(1, 1'b1);

        // Exhaustive sweep on requester 0.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                step(2'b01, 8'(a), 8'(b), 1'b1);
            end
        end
        idle(LAT + 1, 1'b1);

        // Random traffic; a waiting requester holds its operands.
        rv = '0;
        rx = '0;
        ry = '0;
        repeat (600) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(rv[i] && !last_gnt[i])) begin
                    rv[i]        = ($urandom_range(0, 2) != 0);
                    rx[i*W +: W] = W'($urandom);
                    ry[i*W +: W] = W'($urandom);
                end
            end
            step(rv, rx, ry, $urandom_range(0, 3) != 0);
        end
        idle(LAT + 1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Sequential front end that shares one combinational 4x4 unsigned array multiplier (8-bit product) among several requesters. Per-requester valid/ready handshakes are arbitrated round-robin. Each granted operand pair goes through the multiplier, and its product is held in an output register until the consumer accepts it. The block sits between requesting units and the shared multiplier, and is the only path to that datapath.

## Interface

Parameters:
- NREQ, 2, number of requesters; legal values 2..4.
- W, 4, operand width; product width is 2*W. The internal multiplier is built for W=4.
- IDW, 2, width of rsp_id; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  requester i presents an operand pair.
- req_ready  out  NREQ  one-hot or zero; bit i high means requester i is granted this cycle.
- req_x  in  NREQ*W  packed operand x; requester i uses bits [i*W +: W].
- req_y  in  NREQ*W  packed operand y; same packing as req_x.
- rsp_valid  out  1  output register holds a product.
- rsp_ready  in  1  consumer accepts the product.
- rsp_o  out  2*W  product x*y, unsigned.
- rsp_id  out  IDW  index of the requester that issued the product.

## Operation

Transfers:
- A request transfer occurs when req_valid[i] and req_ready[i] are both high.
- A response transfer occurs when rsp_valid and rsp_ready are both high.

Arbitration:
- The round-robin pointer rr (IDW bits) names the highest-priority requester.
- The grant goes to the first i with req_valid[i] set, searching rr, rr+1, … modulo NREQ.
- After a granted transfer, rr becomes (granted index + 1) mod NREQ.
- With no transfer, rr holds.

Space rule:
- req_ready is asserted only when the pipeline can take an entry. That means the stage feeding the output is empty, or that stage is itself advancing this cycle.
- req_ready depends combinationally on req_valid, rr, the stage valid bits and rsp_ready.
- req_ready never depends on operand values.

Output stage state machine:
- EMPTY → FULL on a request transfer.
- FULL → FULL when a response and a request transfer happen in the same cycle; the output register is overwritten with the new product and id.
- FULL → EMPTY on a response transfer with no request transfer.
- FULL holds when rsp_ready is low. rsp_o and rsp_id stay stable, and req_ready is all zero.

Arithmetic:
- rsp_o = zero-extended x times zero-extended y, giving 2*W bits.
- No rounding, no signed mode, and no overflow is possible.

Reset (asserting rst at any time, including mid-transfer):
- rsp_valid = 0, rsp_o = 0, rsp_id = 0, rr = 0, all stage valid bits = 0.
- req_ready is therefore 0 while rst is high.
- In-flight products are dropped.

Requester obligation:
- A requester must hold req_x and req_y stable while req_valid is high and it is not yet granted.
- The block does not check this.

## Timing

- Base latency: a request transfer in cycle t gives rsp_valid high from cycle t+1 with that product.
- Throughput: one product per cycle while rsp_ready stays high.
- Simultaneous response and request transfer: no bubble.
- After rst deasserts: the first request transfer can happen in the first clock edge cycle with rst low.
- No combinational path from req_x/req_y to any output.

## Configuration

The feature is controlled by MULT_ARB_PIPE_EN.

When defined:
- An operand register stage is added before the multiplier, holding x, y, id and a valid bit. The product register follows.
- Latency becomes 2 cycles (request at t, response at t+2).
- Capacity becomes 2 entries.
- The operand stage advances when the product stage is empty or is transferring out.
- req_ready follows the space rule applied to the operand stage.
- Reset clears both stages.

When undefined:
- Single product register only.
- Latency 1, capacity 1.

## Test plan

- **Basic product.** Release reset; req_valid=01, req_x[0]=4'hF, req_y[0]=4'hF, rsp_ready=1. Expect req_ready=01, then next cycle rsp_valid=1, rsp_o=8'hE1, rsp_id=0. With MULT_ARB_PIPE_EN, expect the response one cycle later.
- **Round-robin fairness.** Hold req_valid=11 with rsp_ready=1 for 4 cycles. Expect grants 0,1,0,1 and rsp_id sequence 0,1,0,1. Products: req0 3*5=8'h0F, req1 7*9=8'h3F.
- **Backpressure.** Load one product 6*6, then drop rsp_ready for 3 cycles. Expect rsp_o=8'h24 stable, rsp_valid=1 and req_ready=00 throughout. Raise rsp_ready; expect the transfer and a new grant in the same cycle.
- **Reset mid-operation.** Assert rst while rsp_valid=1 holding 8'h24. Expect asynchronously rsp_valid=0, rsp_o=0, rsp_id=0, req_ready=00. After release, the first grant goes to requester 0 even though requester 1 was next.
- **Idle and zero operands.** With all req_valid=0, expect rsp_valid to stay 0 and rr to hold. Then 0*4'hF on requester 1: expect rsp_o=8'h00, rsp_id=1.
- **Exhaustive multiply.** Sweep all 256 operand pairs on requester 0 with rsp_ready=1, and compare every rsp_o to the x*y model.
